// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI byte-engine arbiter.
package spi_arb_pkg;
  typedef enum logic [2:0] {IDLE, OWNED, XFER, GAP, RELEASE} arb_state_e;

  localparam int CS_FLASH = 0;
  localparam int CS_SD    = 1;
  localparam logic [7:0] READ_FILL = 8'hFF;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/spi_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick; remembers the last owner so a contested grant alternates.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_owner,
  output logic       pick,
  output logic       any
);
  logic last_owner;

  always_ff @(posedge clk) begin
    if (!rst_n)   last_owner <= 1'b1;
    else if (upd) last_owner <= upd_owner;
  end

  always_comb begin
    any  = |req;
    pick = (req == 2'b11) ? ~last_owner : req[1];
  end
endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI byte engine between the boot loader (req 0) and the CPU port (req 1),
// timing the engine's level-held strobes since the engine itself reports no busy.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int XFER_CYCLES = 17,
  parameter int GAP_CYCLES  = 2,
  parameter int NUM_CS      = 2,
  localparam int CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_lock,
  input  logic [1:0]        req_start,
  input  logic [1:0]        req_rd,
  input  logic [15:0]       req_din,
  input  logic [2*CSW-1:0]  req_cs_sel,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [1:0]        done,
  output logic [7:0]        rdata,
  output logic              eng_send,
  output logic              eng_recv,
  output logic [7:0]        eng_din,
  input  logic [7:0]        eng_dout,
  output logic [NUM_CS-1:0] cs_n
);
  localparam int CNTW = $clog2(max2(XFER_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNTW-1:0] XFER_LAST = CNTW'(XFER_CYCLES - 1);
  localparam logic [CNTW-1:0] GAP_LAST  = CNTW'(GAP_CYCLES - 1);

  arb_state_e      state, state_nx;
  logic [CNTW-1:0] cnt;
  logic            owner, rd_lat;
  logic [7:0]      din_lat;
  logic [CSW-1:0]  sel_lat, cs_pick;
  logic            pick, any, owned;

  rr_arb2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_lock),
    .upd       (state == RELEASE),
    .upd_owner (owner),
    .pick      (pick),
    .any       (any)
  );

  assign cs_pick = pick ? req_cs_sel[2*CSW-1:CSW] : req_cs_sel[CSW-1:0];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any) state_nx = OWNED;
      OWNED:   if (!req_lock[owner])      state_nx = RELEASE;
               else if (req_start[owner]) state_nx = XFER;
      XFER:    if (cnt == XFER_LAST) state_nx = GAP;
      GAP:     if (cnt == GAP_LAST)  state_nx = req_lock[owner] ? OWNED : RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      owner   <= 1'b0;
      rd_lat  <= 1'b0;
      din_lat <= READ_FILL;
      sel_lat <= '0;
      rdata   <= 8'h00;
    end else begin
      state <= state_nx;
      if (state_nx != state)                cnt <= '0;
      else if (state == XFER || state == GAP) cnt <= cnt + 1'b1;
      if (state == IDLE && any) begin
        owner   <= pick;
        sel_lat <= cs_pick;
      end
      if (state == OWNED && state_nx == XFER) begin
        rd_lat  <= req_rd[owner];
        din_lat <= owner ? req_din[15:8] : req_din[7:0];
      end
      // Engine data is only valid while the read strobe is still held.
      if (state == XFER && cnt == XFER_LAST && rd_lat) rdata <= eng_dout;
    end
  end

  always_comb begin
    owned    = (state == OWNED) || (state == XFER) || (state == GAP);
    grant    = owned ? (owner ? 2'b10 : 2'b01) : 2'b00;
    busy     = (state == XFER) || (state == GAP);
    done     = (state == GAP && cnt == '0) ? grant : 2'b00;
    eng_send = (state == XFER) && !rd_lat;
    eng_recv = (state == XFER) && rd_lat;
    eng_din  = eng_send ? din_lat : READ_FILL;
    cs_n     = '1;
    if (owned) cs_n[sel_lat] = 1'b0;
  end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: grant/CS, strobe timing, done, round robin, resets.
module tb_spi_bus_arbiter;
  import spi_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_lock, req_start, req_rd, grant, done, cs_n, req_cs_sel;
  logic [15:0] req_din;
  logic        busy, eng_send, eng_recv;
  logic [7:0]  rdata, eng_din, eng_dout;

  int total = 0;
  int passed = 0;

  localparam int W = 25;
  logic       s_send[W], s_recv[W], s_busy[W];
  logic [1:0] s_done[W], s_grant[W], s_cs[W];
  logic [7:0] s_din[W], s_rdata[W];

  always #5 clk = ~clk;

  // Engine model: returns 3C only while the read strobe is held.
  assign eng_dout = eng_recv ? 8'h3C : 8'h00;

  spi_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_lock(req_lock), .req_start(req_start),
    .req_rd(req_rd), .req_din(req_din), .req_cs_sel(req_cs_sel), .grant(grant),
    .busy(busy), .done(done), .rdata(rdata), .eng_send(eng_send),
    .eng_recv(eng_recv), .eng_din(eng_din), .eng_dout(eng_dout), .cs_n(cs_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Records W cycles starting just after the edge that sampled start.
  task automatic run_xfer(input int drop_at, input bit noise);
    for (int i = 0; i < W; i++) begin
      s_send[i]  = eng_send;  s_recv[i]  = eng_recv;  s_busy[i] = busy;
      s_done[i]  = done;      s_grant[i] = grant;     s_cs[i]   = cs_n;
      s_din[i]   = eng_din;   s_rdata[i] = rdata;
      chk("strobe_excl", {31'd0, eng_send & eng_recv}, 32'd0);
      if (noise) req_start = (i < 17) ? 2'b10 : (i < 19) ? 2'b11 : 2'b00;
      if (i == drop_at) req_lock = 2'b00;
      tick();
    end
  endtask

  task automatic check_profile(input string tag, input int e_send, input int e_recv,
                               input logic [1:0] e_done, input logic [7:0] e_din0);
    int ns, nr, nb, nd, di;
    ns = 0; nr = 0; nb = 0; nd = 0; di = -1;
    for (int i = 0; i < W; i++) begin
      ns += int'(s_send[i]);
      nr += int'(s_recv[i]);
      nb += int'(s_busy[i]);
      if (s_done[i] != 2'b00) begin
        nd++;
        if (di < 0) di = i;
      end
    end
    chk({tag, "_send_cycles"}, ns, e_send);
    chk({tag, "_recv_cycles"}, nr, e_recv);
    chk({tag, "_busy_cycles"}, nb, 19);
    chk({tag, "_done_count"}, nd, 1);
    chk({tag, "_done_idx"}, di, 17);
    chk({tag, "_done_val"}, {30'd0, s_done[17]}, {30'd0, e_done});
    chk({tag, "_strobe_first"}, {31'd0, s_send[0] | s_recv[0]}, 32'd1);
    chk({tag, "_eng_din"}, {24'd0, s_din[0]}, {24'd0, e_din0});
  endtask

  initial begin
    rst_n = 1'b0; req_lock = 2'b00; req_start = 2'b00; req_rd = 2'b00;
    req_din = 16'h0000; req_cs_sel = 2'b00;
    tick(); tick();
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 2'b00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_eng_din", eng_din, 8'hFF);
    chk("rst_cs_n", cs_n, 2'b11);
    chk("rst_strobes", {eng_send, eng_recv}, 2'b00);
    rst_n = 1'b1;

    // req0 write A5 to flash
    req_cs_sel = 2'(CS_FLASH); req_lock = 2'b01;
    tick();
    chk("t1_grant", grant, 2'b01);
    chk("t1_cs_n", cs_n, 2'b10);
    req_din = 16'h00A5; req_start = 2'b01;
    tick();
    req_start = 2'b00;
    run_xfer(-1, 1'b0);
    check_profile("t1", 17, 0, 2'b01, 8'hA5);
    chk("t1_idle_busy", busy, 0);
    chk("t1_still_owned", grant, 2'b01);
    req_lock = 2'b00;
    tick();
    chk("t1_rel_grant", grant, 2'b00);
    chk("t1_rel_cs_n", cs_n, 2'b11);
    tick();

    // req1 read from SD
    req_cs_sel = 2'(CS_SD) << 1; req_lock = 2'b10;
    tick();
    chk("t2_grant", grant, 2'b10);
    chk("t2_cs_n", cs_n, 2'b01);
    req_rd = 2'b10; req_din = 16'h7700; req_start = 2'b10;
    tick();
    req_start = 2'b00;
    run_xfer(-1, 1'b0);
    check_profile("t2", 0, 17, 2'b10, 8'hFF);
    chk("t2_rdata_at_done", s_rdata[17], 8'h3C);
    chk("t2_rdata_hold", rdata, 8'h3C);
    req_lock = 2'b00; req_rd = 2'b00;
    tick(); tick();

    // both lock after reset: req0 first, req1 after release
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_cs_sel = 2'b10; req_lock = 2'b11;
    tick();
    chk("t3_grant0", grant, 2'b01);
    chk("t3_cs_n0", cs_n, 2'b10);
    req_lock = 2'b10;
    tick();
    chk("t3_rel_grant", grant, 2'b00);
    chk("t3_rel_cs_n", cs_n, 2'b11);
    tick(); tick();
    chk("t3_grant1", grant, 2'b10);
    chk("t3_cs_n1", cs_n, 2'b01);

    // ignored starts: non-owner start, owner start during gap
    req_lock = 2'b00;
    tick(); tick();
    req_cs_sel = 2'b00; req_lock = 2'b01;
    tick();
    chk("t4_grant", grant, 2'b01);
    req_start = 2'b10;
    tick(); tick();
    chk("t4_nonowner_busy", busy, 0);
    chk("t4_nonowner_done", done, 2'b00);
    chk("t4_nonowner_grant", grant, 2'b01);
    req_din = 16'h005A; req_start = 2'b01;
    tick();
    req_start = 2'b00;
    run_xfer(-1, 1'b1);
    check_profile("t4", 17, 0, 2'b01, 8'h5A);
    chk("t4_after_busy", busy, 0);

    // lock dropped mid-transfer
    req_din = 16'h00C3; req_start = 2'b01;
    tick();
    req_start = 2'b00;
    run_xfer(5, 1'b0);
    check_profile("t5", 17, 0, 2'b01, 8'hC3);
    chk("t5_gap_grant", s_grant[18], 2'b01);
    chk("t5_rel_grant", s_grant[19], 2'b00);
    chk("t5_rel_cs_n", s_cs[19], 2'b11);

    // reset in the middle of a transfer
    req_lock = 2'b01;
    tick();
    req_din = 16'h0011; req_start = 2'b01;
    tick();
    req_start = 2'b00;
    for (int i = 0; i < 8; i++) tick();
    chk("t6_mid_send", eng_send, 1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_grant", grant, 2'b00);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 2'b00);
    chk("t6_rst_strobes", {eng_send, eng_recv}, 2'b00);
    chk("t6_rst_eng_din", eng_din, 8'hFF);
    chk("t6_rst_cs_n", cs_n, 2'b11);
    chk("t6_rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_done", done, 2'b00);
    end
    chk("t6_regrant", grant, 2'b01);
    req_din = 16'h0081; req_start = 2'b01;
    tick();
    req_start = 2'b00;
    run_xfer(-1, 1'b0);
    check_profile("t6", 17, 0, 2'b01, 8'h81);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
